aes_key_expand_seq: RTL and testbench
=====================================

AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 SHALL have parameter NROUNDS, default 10, number of round keys after round 0 (AES-128 only).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request expansion of key_in (sampled in IDLE only).
REQ-005 SHALL have port key_in, input, 128, cipher key, byte 0 in bits [127:120].
REQ-006 SHALL have port busy, output, 1, high while in EXPAND state.
REQ-007 SHALL have port rk_valid, output, 1, rk_out/rk_round valid this cycle.
REQ-008 SHALL have port rk_round, output, 4, index 0..10 of the current rk_out.
REQ-009 SHALL have port rk_out, output, 128, round key, FIPS-197 word order w0 in [127:96].
REQ-010 SHALL have port done, output, 1, single-cycle pulse coincident with round 10 key.

Function
REQ-011 SHALL implement FSM states IDLE and EXPAND only.
REQ-012 SHALL, in IDLE with start=1, register key_in into the key register, set rk_round=0, and enter EXPAND.
REQ-013 SHALL assert rk_valid with rk_out=key_in and rk_round=0 on the cycle after start is sampled (latency 1).
REQ-014 SHALL, each EXPAND cycle with rk_round<10, load rk_out with the next round key and increment rk_round, keeping rk_valid=1.
REQ-015 SHALL compute next key as: t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-016 SHALL use rcon for transition to round r (r=1..10): 01,02,04,08,10,20,40,80,1B,36, from a table indexed by rk_round.
REQ-017 SHALL assert done=1 exactly in the cycle rk_round=10 and rk_valid=1, then return to IDLE at the next edge.
REQ-018 SHALL deassert rk_valid in IDLE; rk_out and rk_round SHALL hold their last values in IDLE.
REQ-019 SHALL ignore start while busy=1; the expansion in progress SHALL NOT restart or stall.
REQ-020 SHALL accept start in the cycle immediately after done (back-to-back), giving round 0 of the new key one cycle later.
REQ-021 SHALL present exactly 11 consecutive rk_valid cycles per accepted start, with no gaps.
REQ-022 SHALL NOT depend on key_in after the start cycle.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force state=IDLE, busy=0, rk_valid=0, done=0, rk_round=0, rk_out=128'h0.
REQ-024 SHALL give rst priority over start and abort any expansion mid-operation, with no further rk_valid or done.
REQ-025 SHALL accept a start in the first cycle after rst deasserts.

Structure
REQ-026 SHALL place the rcon table, NROUNDS, and the FSM state encoding in shared package aes_pkg.
REQ-027 SHALL instantiate four copies of combinational sub-module aes_sbox (8-bit in, 8-bit out, FIPS-197 S-box) for SubWord.
REQ-028 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-029 SHALL verify FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c -> round 1 a0fafe1788542cb123a339392a6c7605; round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1.
REQ-030 SHALL verify an all-zero key -> round 1 62636363626363636263636362636363; round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 SHALL verify start pulsed again at rounds 3 and 7 -> ignored; sequence and done timing unchanged (done 11 cycles after the first accepted start).
REQ-032 SHALL verify rst asserted at rk_round=5 -> next cycle all outputs at reset values; no done; a new start one cycle after rst completes correctly.
REQ-033 SHALL verify start held high continuously -> back-to-back expansions: 11 valid cycles, 1 IDLE cycle, then 11 valid cycles.
REQ-034 SHALL verify with a self-checking reference model over 1000 random keys that all 11 round keys match for each key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES-128 key expander: round count,
// FSM state encoding and the round-constant lookup.
package aes_pkg;

    localparam int NROUNDS = 10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_e;

    // Round constant for the transition from round index `round` to round+1.
    function automatic logic [7:0] rcon_for(input logic [3:0] round);
        logic [7:0] v;
        case (round)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197), one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_data = SBOX[i_data];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits the cipher key and one new round key
// per clock, 11 consecutive valid cycles per accepted start.
//
//   state    | meaning
//   S_IDLE   | waiting for start; outputs hold last key/round, rk_valid low
//   S_EXPAND | one round key presented per cycle, rounds 0..NROUNDS
module aes_key_expand_seq #(
    parameter int NROUNDS = aes_pkg::NROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    state_e       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_done;

    state_e       w_state_nxt;
    logic [127:0] w_key_nxt;
    logic [3:0]   w_round_nxt;
    logic         w_valid_nxt;
    logic         w_done_nxt;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [127:0] w_key_step;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_data (w_rot[8*g +: 8]),
                .o_data (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_t        = w_sub ^ {rcon_for(r_round), 24'h0};
    assign w_w0       = r_key[127:96] ^ w_t;
    assign w_w1       = r_key[95:64]  ^ w_w0;
    assign w_w2       = r_key[63:32]  ^ w_w1;
    assign w_w3       = r_key[31:0]   ^ w_w2;
    assign w_key_step = {w_w0, w_w1, w_w2, w_w3};

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EXPAND;
                    w_key_nxt   = key_in;
                    w_round_nxt = 4'd0;
                    w_valid_nxt = 1'b1;
                end
            end
            S_EXPAND: begin
                if (r_round < LAST_ROUND) begin
                    w_key_nxt   = w_key_step;
                    w_round_nxt = r_round + 4'd1;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = (r_round + 4'd1 == LAST_ROUND);
                end else begin
                    // Last key was shown with done this cycle; outputs hold in IDLE.
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= 128'h0;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy     = (r_state == S_EXPAND);
    assign rk_valid = r_valid;
    assign rk_round = r_round;
    assign rk_out   = r_key;
    assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed and random-key bench for aes_key_expand_seq; expected round keys
// come from FIPS-197 vectors and a GF(2^8)-derived S-box reference model.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];

    aes_key_expand_seq #(.NROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb  = 8'(x);
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        logic [31:0] a, b, c, d;
        t = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
        a = k[127:96] ^ t;
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic build_expected(input logic [127:0] key);
        logic [7:0] rc = 8'h01;
        exp_keys[0] = key;
        for (int r = 1; r <= 10; r++) begin
            exp_keys[r] = model_next(exp_keys[r-1], rc);
            rc = xtime(rc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; key_in = {4{32'hdeadbeef}};
        tick(); tick();
        checks++;
        if ({busy, rk_valid, done} !== 3'b000 || rk_round !== 4'd0 || rk_out !== 128'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b valid=%b done=%b round=%0d out=%h exp all zero",
                     busy, rk_valid, done, rk_round, rk_out);
        end
        start = 1'b0;
    endtask

    // Starts immediately in the first cycle after reset release.
    task automatic test_fips_vector();
        build_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rst = 1'b0; start = 1'b1; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tick();
        start = 1'b0; key_in = 128'h0;
        checks++;
        if (!rk_valid || !busy || rk_round !== 4'd0 || rk_out !== 128'h2b7e151628aed2a6abf7158809cf4f3c || done) begin
            failures++;
            $display("FAIL fips_round0 valid=%b round=%0d out=%h exp 1/0/2b7e1516..", rk_valid, rk_round, rk_out);
        end
        tick();
        checks++;
        if (rk_round !== 4'd1 || rk_out !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            failures++;
            $display("FAIL fips_round1 round=%0d out=%h exp a0fafe1788542cb123a339392a6c7605", rk_round, rk_out);
        end
        for (int r = 2; r <= 10; r++) begin
            tick();
            checks++;
            if (!rk_valid || rk_round !== 4'(r) || rk_out !== exp_keys[r] || done !== (r == 10)) begin
                failures++;
                $display("FAIL fips_round%0d valid=%b round=%0d done=%b out=%h exp %h", r, rk_valid, rk_round, done, rk_out, exp_keys[r]);
            end
        end
        checks++;
        if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || done !== 1'b1) begin
            failures++;
            $display("FAIL fips_round10 out=%h done=%b exp d014f9a8c9ee2589e13f0cc8b6630ca6 done=1", rk_out, done);
        end
        tick();
        checks++;
        if (rk_valid || busy || done || rk_round !== 4'd10 || rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            failures++;
            $display("FAIL fips_idle_hold valid=%b busy=%b done=%b round=%0d out=%h exp 0/0/0/10/d014..", rk_valid, busy, done, rk_round, rk_out);
        end
    endtask

    task automatic test_zero_key();
        start = 1'b1; key_in = 128'h0;
        tick();
        start = 1'b0; key_in = {4{32'hffffffff}};
        tick();
        checks++;
        if (rk_round !== 4'd1 || rk_out !== 128'h62636363626363636263636362636363) begin
            failures++;
            $display("FAIL zero_round1 round=%0d out=%h exp 62636363626363636263636362636363", rk_round, rk_out);
        end
        repeat (9) tick();
        checks++;
        if (rk_round !== 4'd10 || !done || rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            failures++;
            $display("FAIL zero_round10 round=%0d done=%b out=%h exp b4ef5bcb3e92e21123e951cf6f8f188e", rk_round, done, rk_out);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        build_expected(128'h000102030405060708090a0b0c0d0e0f);
        start = 1'b1; key_in = 128'h000102030405060708090a0b0c0d0e0f;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (!rk_valid || rk_round !== 4'(c) || rk_out !== exp_keys[c] || done !== (c == 10)) begin
                failures++;
                $display("FAIL ignore_start cycle=%0d valid=%b round=%0d done=%b out=%h exp %h", c, rk_valid, rk_round, done, rk_out, exp_keys[c]);
            end
            start  = (c == 3 || c == 7);
            key_in = {4{32'h55aa55aa}};
            tick();
            start = 1'b0;
        end
        checks++;
        if (rk_valid || busy || done) begin
            failures++;
            $display("FAIL ignore_start_end valid=%b busy=%b done=%b exp 0/0/0", rk_valid, busy, done);
        end
    endtask

    task automatic test_reset_abort();
        start = 1'b1; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (rk_round !== 4'd5) begin
            failures++;
            $display("FAIL abort_reach5 round=%0d exp 5", rk_round);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, rk_valid, done} !== 3'b000 || rk_round !== 4'd0 || rk_out !== 128'h0) begin
            failures++;
            $display("FAIL abort_reset busy=%b valid=%b done=%b round=%0d out=%h exp all zero", busy, rk_valid, done, rk_round, rk_out);
        end
        tick();
        checks++;
        if ({busy, rk_valid, done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_no_resume busy=%b valid=%b done=%b exp 0/0/0", busy, rk_valid, done);
        end
        build_expected(128'h0f1571c947d9e8590cb7add6af7f6798);
        start = 1'b1; key_in = 128'h0f1571c947d9e8590cb7add6af7f6798;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (!rk_valid || rk_round !== 4'(c) || rk_out !== exp_keys[c] || done !== (c == 10)) begin
                failures++;
                $display("FAIL abort_restart cycle=%0d valid=%b round=%0d done=%b out=%h exp %h", c, rk_valid, rk_round, done, rk_out, exp_keys[c]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
        build_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start = 1'b1; key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tick();
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (!rk_valid || rk_round !== 4'(c) || rk_out !== exp_keys[c] || done !== (c == 10)) begin
                failures++;
                $display("FAIL b2b_first cycle=%0d valid=%b round=%0d done=%b out=%h exp %h", c, rk_valid, rk_round, done, rk_out, exp_keys[c]);
            end
            if (c == 10) key_in = k2;
            tick();
        end
        checks++;
        if (rk_valid || busy) begin
            failures++;
            $display("FAIL b2b_gap valid=%b busy=%b exp 0/0", rk_valid, busy);
        end
        build_expected(k2);
        tick();
        for (int c = 0; c <= 10; c++) begin
            checks++;
            if (!rk_valid || rk_round !== 4'(c) || rk_out !== exp_keys[c] || done !== (c == 10)) begin
                failures++;
                $display("FAIL b2b_second cycle=%0d valid=%b round=%0d done=%b out=%h exp %h", c, rk_valid, rk_round, done, rk_out, exp_keys[c]);
            end
            if (c == 10) start = 1'b0;
            tick();
        end
        checks++;
        if (rk_valid || busy) begin
            failures++;
            $display("FAIL b2b_stop valid=%b busy=%b exp 0/0", rk_valid, busy);
        end
    endtask

    task automatic test_random_keys();
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
            build_expected(k);
            start = 1'b1; key_in = k;
            tick();
            start = 1'b0; key_in = ~k;
            for (int c = 0; c <= 10; c++) begin
                checks++;
                if (!rk_valid || rk_round !== 4'(c) || rk_out !== exp_keys[c] || done !== (c == 10)) begin
                    failures++;
                    if (bad < 10)
                        $display("FAIL random key=%h round=%0d valid=%b done=%b out=%h exp %h", k, c, rk_valid, done, rk_out, exp_keys[c]);
                    bad++;
                end
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_in = 128'h0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_zero_key();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random_keys();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
